// File: rtl/puf_eval_controller.sv
// puf_eval_controller: drives an arbiter PUF through majority-voted evaluations, one LFSR challenge per response bit.
module puf_eval_controller #(
  parameter int SIZE = 8,
  parameter int RESP_BITS = 16,
  parameter int VOTES = 5,
  parameter int SETTLE = 4,
  parameter logic [SIZE-1:0] TAPS = 8'hB8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           Start,
  input  logic                           Abort,
  input  logic [SIZE-1:0]                Seed,
  output logic                           PufEnable,
  output logic [SIZE-1:0]                PufChallenge,
  input  logic                           PufResponse,
  output logic                           Busy,
  output logic                           Done,
  output logic [RESP_BITS-1:0]           ResponseWord,
  output logic [$clog2(RESP_BITS+1)-1:0] UnstableCount
);
  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = $clog2(RESP_BITS + 1);
  localparam int UW = $clog2(RESP_BITS + 1);
  localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
  localparam logic [VW-1:0] VOTES_W = VW'(VOTES);
  localparam logic [VW-1:0] VOTE_LAST = VW'(VOTES - 1);
  localparam logic [VW-1:0] HALF = VW'(VOTES / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(RESP_BITS - 1);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, RESOLVE, DONE} state_t;
  state_t state, next;
  logic [7:0] phase;
  logic [VW-1:0] votes, ones;
  logic [BW-1:0] bits;
  logic [SIZE-1:0] lfsr;
  logic phase_last, start_acc, active;
  assign phase_last = phase == SET_LAST;
  assign active = state == LOW || state == HIGH || state == RESOLVE;
  assign start_acc = state == IDLE && Start && !Abort;
  assign PufChallenge = lfsr;
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    PufEnable = state == HIGH;
    Busy = active;
    Done = state == DONE;
    case (state)
      IDLE:    next = start_acc ? LOW : IDLE;
      LOW:     next = Abort ? IDLE : phase_last ? HIGH : LOW;
      HIGH:    next = Abort ? IDLE : !phase_last ? HIGH : votes == VOTE_LAST ? RESOLVE : LOW;
      RESOLVE: next = Abort ? IDLE : bits == BIT_LAST ? DONE : LOW;
      default: next = IDLE;
    endcase
  end
  // An aborted cycle leaves the datapath untouched so partial results survive.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      votes <= '0;
      ones <= '0;
      bits <= '0;
      lfsr <= SIZE'(1);
      ResponseWord <= '0;
      UnstableCount <= '0;
    end else begin
      phase <= ((state == LOW || state == HIGH) && !phase_last && !Abort) ? phase + 8'd1 : 8'd0;
      if (start_acc) begin
        lfsr <= Seed == '0 ? SIZE'(1) : Seed;
        votes <= '0;
        ones <= '0;
        bits <= '0;
        ResponseWord <= '0;
        UnstableCount <= '0;
      end
      if (state == HIGH && phase_last && !Abort) begin
        votes <= votes + VW'(1);
        ones <= ones + VW'(PufResponse);
      end
      if (state == RESOLVE && !Abort) begin
        ResponseWord <= (ResponseWord << 1) | RESP_BITS'(ones > HALF);
        UnstableCount <= UnstableCount + UW'(ones != '0 && ones != VOTES_W);
        votes <= '0;
        ones <= '0;
        bits <= bits + BW'(1);
        lfsr <= lfsr[0] ? (lfsr >> 1) ^ TAPS : lfsr >> 1;
      end
    end
  end
endmodule

// File: tb/tb_puf_eval_controller.sv
// tb_puf_eval_controller: directed checks of voting, LFSR challenges, enable waveform, abort and reset.
module tb_puf_eval_controller;
  logic clk = 0, reset = 1, Start = 0, Abort = 0, PufResponse = 0;
  logic [7:0] Seed = 0;
  logic PufEnable, Busy, Done;
  logic [7:0] PufChallenge;
  logic [15:0] ResponseWord;
  logic [4:0] UnstableCount;
  int checks = 0, errors = 0;
  int lat, en_err, chal_err;
  logic [7:0] c1, c42, c83;
  logic rs_busy, rs_en, post_busy, post_en;
  logic [15:0] post_resp;
  logic [7:0] post_chal;
  logic [4:0] post_unst;
  logic [4:0] pv = 5'b01011;
  puf_eval_controller dut (
    .clk(clk), .reset(reset), .Start(Start), .Abort(Abort), .Seed(Seed),
    .PufEnable(PufEnable), .PufChallenge(PufChallenge), .PufResponse(PufResponse),
    .Busy(Busy), .Done(Done), .ResponseWord(ResponseWord), .UnstableCount(UnstableCount)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [7:0] seed, input bit pat, input int abort_at, input int reset_at, input bit hold);
    int p, stop;
    stop = abort_at != 0 ? abort_at : reset_at;
    @(negedge clk);
    Seed = seed;
    Start = 1;
    PufResponse = 1;
    @(posedge clk);
    #1 if (!hold) Start = 0;
    lat = 0; en_err = 0; chal_err = 0;
    for (int n = 1; n <= 800; n++) begin
      @(negedge clk);
      p = (n - 1) % 41;
      PufResponse = (pat && p < 40) ? pv[p / 8] : 1'b1;
      if (n == 1) c1 = PufChallenge;
      if (n == 42) c42 = PufChallenge;
      if (n == 83) c83 = PufChallenge;
      if (n <= 40) begin
        if (PufEnable !== (p % 8 >= 4)) en_err++;
        if (PufChallenge !== c1) chal_err++;
      end
      if (n == 41) begin rs_busy = Busy; rs_en = PufEnable; end
      if (Done) begin lat = n; break; end
      if (n == abort_at) Abort = 1;
      if (n == reset_at) reset = 1;
      if (stop != 0 && n == stop + 1) begin
        Abort = 0; reset = 0;
        post_busy = Busy; post_en = PufEnable; post_resp = ResponseWord;
        post_chal = PufChallenge; post_unst = UnstableCount;
      end
      if (stop != 0 && n == stop + 30) break;
    end
    Start = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", PufEnable, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_resp", ResponseWord, 0);
    check("rst_unst", UnstableCount, 0);
    check("rst_chal", PufChallenge, 8'h01);
    reset = 0;
    run(8'h5A, 0, 0, 0, 0);
    check("stuck_lat", lat, 657);
    check("stuck_resp", ResponseWord, 16'hFFFF);
    check("stuck_unst", UnstableCount, 0);
    check("stuck_done_busy", Busy, 0);
    check("stuck_c1", c1, 8'h5A);
    check("stuck_c42", c42, 8'h2D);
    check("enable_wave", en_err, 0);
    check("chal_stable", chal_err, 0);
    check("resolve_busy", rs_busy, 1);
    check("resolve_en", rs_en, 0);
    run(8'h01, 1, 0, 0, 0);
    check("split_lat", lat, 657);
    check("split_resp", ResponseWord, 16'hFFFF);
    check("split_unst", UnstableCount, 16);
    check("seq_c42", c42, 8'hB8);
    check("seq_c83", c83, 8'h5C);
    repeat (5) @(negedge clk);
    check("hold_resp", ResponseWord, 16'hFFFF);
    check("hold_unst", UnstableCount, 16);
    check("hold_busy", Busy, 0);
    Start = 1; Abort = 1;
    repeat (3) @(negedge clk);
    check("start_abort_busy", Busy, 0);
    check("start_abort_en", PufEnable, 0);
    Start = 0; Abort = 0;
    run(8'h00, 0, 0, 0, 0);
    check("zero_seed_c1", c1, 8'h01);
    check("zero_seed_lat", lat, 657);
    run(8'h33, 0, 100, 0, 0);
    check("abort_no_done", lat, 0);
    check("abort_busy", post_busy, 0);
    check("abort_en", post_en, 0);
    check("abort_partial", post_resp, 16'h0003);
    check("abort_idle_busy", Busy, 0);
    run(8'h33, 0, 0, 0, 0);
    check("after_abort_lat", lat, 657);
    run(8'h77, 0, 0, 87, 0);
    check("reset_no_done", lat, 0);
    check("reset_en", post_en, 0);
    check("reset_busy", post_busy, 0);
    check("reset_resp", post_resp, 0);
    check("reset_unst", post_unst, 0);
    check("reset_chal", post_chal, 8'h01);
    run(8'h5A, 0, 0, 0, 1);
    check("held_start_lat", lat, 657);
    check("held_start_resp", ResponseWord, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
